piso_frame_feeder: RTL and testbench

//  Upstream feeder for the bidirectional shift register. Accepts an N-bit parallel word

---
 rtl/piso_frame_feeder.sv | 95 +++++++++
 tb/tb_piso_frame_feeder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piso_frame_feeder.sv
// Parallel-in serial-out frame feeder: accepts an N-bit word plus direction over
// valid/ready and streams it one bit per clock, with stall and a done pulse.
module piso_frame_feeder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    input  logic         load_dir,
    input  logic         stall,
    output logic         ser_data,
    output logic         ser_mode,
    output logic         ser_valid,
    output logic         busy,
    output logic         done
);

    // state | meaning
    // IDLE  | waiting for a word, load_ready high
    // SHIFT | presenting bit idx of the captured word
    // DONE  | one-cycle completion pulse
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    shreg_q;
    logic [CW-1:0]   idx_q;
    logic [CW-1:0]   idx_d;
    logic            dir_q;
    logic [CW-1:0]   bit_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && load_valid) begin
                shreg_q <= load_data;
                dir_q   <= load_dir;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = SHIFT;
                    idx_d   = '0;
                end
            end
            SHIFT: begin
                if (!stall) begin
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // LSB-first walks idx upward; MSB-first mirrors it from the top bit.
    assign bit_sel    = dir_q ? idx_q : (LAST - idx_q);
    assign ser_valid  = (state_q == SHIFT);
    assign ser_data   = ser_valid & shreg_q[bit_sel];
    assign ser_mode   = dir_q;
    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_piso_frame_feeder.sv
// Randomised bench for piso_frame_feeder: each frame's expected bit stream is
// derived arithmetically from the word and direction, then checked cycle by cycle.
module tb_piso_frame_feeder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data;
    logic         load_dir;
    logic         stall;
    logic         ser_data;
    logic         ser_mode;
    logic         ser_valid;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    piso_frame_feeder #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dir   (load_dir),
        .stall      (stall),
        .ser_data   (ser_data),
        .ser_mode   (ser_mode),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit k of the serial frame: counted from the LSB when dir=1, from the MSB otherwise.
    function automatic logic exp_bit(input logic [N-1:0] w, input logic d, input int k);
        return d ? w[k] : w[N-1-k];
    endfunction

    task automatic chk_idle(input string tag, input logic mode);
        chk({tag, "_ready"}, load_ready, 1);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_valid"}, ser_valid, 0);
        chk({tag, "_data"},  ser_data, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_mode"},  ser_mode, mode);
    endtask

    task automatic run_frame(input logic [N-1:0] w, input logic d,
                             input bit stall_en, input bit junk_en);
        int k;
        int guard;
        chk("pre_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = w;
        load_dir   = d;
        step();
        load_valid = 1'b0;
        k = 0;
        guard = 0;
        while (k < N && guard < 8 * N) begin
            chk("sh_valid", ser_valid, 1);
            chk("sh_data",  ser_data, exp_bit(w, d, k));
            chk("sh_mode",  ser_mode, d);
            chk("sh_done",  done, 0);
            chk("sh_ready", load_ready, 0);
            chk("sh_busy",  busy, 1);
            stall = stall_en && ($urandom_range(0, 2) == 0);
            if (junk_en) begin
                load_valid = 1'($urandom_range(0, 1));
                load_data  = ~w;
                load_dir   = ~d;
            end
            step();
            if (!stall) k++;
            guard++;
        end
        chk("sh_guard", (k == N) ? 1 : 0, 1);
        chk("dn_done",  done, 1);
        chk("dn_valid", ser_valid, 0);
        chk("dn_data",  ser_data, 0);
        chk("dn_ready", load_ready, 0);
        chk("dn_busy",  busy, 1);
        chk("dn_mode",  ser_mode, d);
        load_valid = 1'b0;
        stall      = 1'($urandom_range(0, 1));
        step();
        stall = 1'b0;
        chk_idle("post", d);
    endtask

    initial begin
        logic [N-1:0] w;
        logic         d;
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = '1;
        load_dir   = 1'b1;
        stall      = 1'b0;

        // reset must override a pending load
        step();
        chk_idle("rst1", 1'b0);
        load_valid = 1'b0;
        step();
        chk_idle("rst2", 1'b0);
        rst = 1'b0;
        step();
        chk_idle("rst_rel", 1'b0);

        run_frame(4'b1010, 1'b1, 1'b0, 1'b0);
        run_frame(4'b1001, 1'b0, 1'b0, 1'b0);
        run_frame(4'b1100, 1'b1, 1'b1, 1'b0);

        // a word offered mid-frame is dropped, then accepted once IDLE
        run_frame(4'b0000, 1'b1, 1'b0, 1'b1);
        run_frame(4'b1111, 1'b1, 1'b0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            w = N'($urandom);
            d = 1'($urandom_range(0, 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                load_valid = 1'b0;
                stall      = 1'($urandom_range(0, 1));
                step();
                stall = 1'b0;
                chk("gap_ready", load_ready, 1);
                chk("gap_busy",  busy, 0);
            end
            run_frame(w, d, 1'b1, 1'($urandom_range(0, 1)));
        end

        // reset mid-frame aborts without a done pulse
        d = 1'($urandom_range(0, 1));
        load_valid = 1'b1;
        load_data  = 4'b0110;
        load_dir   = d;
        step();
        load_valid = 1'b0;
        chk("ab_bit0", ser_data, exp_bit(4'b0110, d, 0));
        step();
        chk("ab_bit1", ser_data, exp_bit(4'b0110, d, 1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("ab_rst", 1'b0);
        step();
        chk_idle("ab_after", 1'b0);
        run_frame(4'b0011, 1'b0, 1'b0, 1'b0);
        run_frame(4'b0011, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
